sipo_deserializer: RTL and testbench

Serial-in/parallel-out receiver for the serial bit stream produced by the team's shift-register chains. Assembles WIDTH consecutive qualified serial bits into a parallel word. Holds the word in a one-entry output buffer with a valid/ready handshake, and flags words lost to back-pressure. Sits at the far end of a serial link, between the serial line and a parallel consumer.

---
 rtl/sipo_deserializer.sv | 87 ++++++++
 tb/tb_sipo_deserializer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in/parallel-out receiver with a one-entry valid/ready output buffer
// Ports:
//   clk         clock; every flop updates on the falling edge
//   reset_n     asynchronous active-low reset
//   sin         serial data bit, sampled when sin_valid is high
//   sin_valid   qualifies sin at this edge
//   clr         synchronous clear of frame assembly and the overflow flag
//   dout        assembled word, first received bit in dout[0]
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer takes dout at an edge where dout_valid is high
//   overflow    sticky, a completed word was dropped because the buffer was full
//   bit_cnt     bits captured so far in the current frame
//   parity_err  present only when SIPO_PARITY_EN is defined; even-parity mismatch on dout
// Option: define SIPO_PARITY_EN to append an even-parity bit after the data bits of every frame.
module sipo_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       sin,
   input  logic                       sin_valid,
   input  logic                       clr,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic                       overflow,
   output logic [$clog2(WIDTH+1)-1:0] bit_cnt
`ifdef SIPO_PARITY_EN
   ,
   output logic                       parity_err
`endif
);
   localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
   logic [WIDTH-1:0] sr, word;
   logic take, last, done, free;
   always_comb begin
      take = sin_valid & ~clr;
      last = bit_cnt == LAST;
      done = take & last;
      free = ~dout_valid | dout_ready;
`ifdef SIPO_PARITY_EN
      // the final bit is the parity bit, so the data is already complete in sr
      word = sr;
`else
      word = {sin, sr[WIDTH-1:1]};
`endif
   end
   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr         <= '0;
         bit_cnt    <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (clr) begin
            sr      <= '0;
            bit_cnt <= '0;
         end else if (take) begin
            bit_cnt <= last ? '0 : bit_cnt + 1'b1;
`ifdef SIPO_PARITY_EN
            if (!last)
`endif
            sr <= {sin, sr[WIDTH-1:1]};
         end
         overflow   <= ~clr & (overflow | (done & ~free));
         dout_valid <= (done & free) | (dout_valid & ~dout_ready);
         if (done & free)
            dout <= word;
      end
   end
`ifdef SIPO_PARITY_EN
   // only a word that actually loads into dout updates its parity flag
   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n)
         parity_err <= 1'b0;
      else if (done & free)
         parity_err <= ^sr ^ sin;
   end
`endif
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed self-checking bench for sipo_deserializer
module tb_sipo_deserializer;
   localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   logic clk = 1'b1, reset_n = 1'b0, sin = 1'b0, sin_valid = 1'b0, clr = 1'b0, dout_ready = 1'b0;
   logic [WIDTH-1:0] dout;
   logic dout_valid, overflow;
   logic [3:0] bit_cnt;
   logic [8:0] f;
   int tests = 0, fails = 0;
`ifdef SIPO_PARITY_EN
   logic parity_err;
`endif
   sipo_deserializer #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .sin(sin),
      .sin_valid(sin_valid),
      .clr(clr),
      .dout(dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .overflow(overflow),
      .bit_cnt(bit_cnt)
`ifdef SIPO_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   task automatic send_bit(input logic b);
      sin = b;
      sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
   endtask
   // frame bits are {parity, data}; dout_ready takes value rl for the final bit only
   task automatic send_frame(input logic [8:0] fr, input logic rl);
      for (int i = 0; i < FRAME; i++) begin
         if (i == FRAME - 1)
            dout_ready = rl;
         send_bit(fr[i]);
      end
   endtask
   function automatic logic [8:0] ep(input logic [7:0] w);
      return {^w, w};
   endfunction
   initial begin
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++)
         send_bit(1'b1);
      check("cnt_pre_reset", bit_cnt, 3);
      #2 reset_n = 1'b0;
      #1;
      check("rst_dout", dout, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_ovf", overflow, 0);
      check("rst_cnt", bit_cnt, 0);
      #2 reset_n = 1'b1;
      dout_ready = 1'b1;
      f = ep(8'h4D);
      for (int i = 0; i < FRAME - 1; i++)
         send_bit(f[i]);
      check("basic_not_yet", dout_valid, 0);
      check("basic_cnt", bit_cnt, FRAME - 1);
      send_bit(f[FRAME-1]);
      check("basic_dout", dout, 8'h4D);
      check("basic_valid", dout_valid, 1);
      check("basic_cnt_wrap", bit_cnt, 0);
`ifdef SIPO_PARITY_EN
      check("basic_perr", parity_err, 0);
`endif
      tick();
      check("basic_one_cycle", dout_valid, 0);
      for (int i = 0; i < FRAME; i++) begin
         send_bit(f[i]);
         if (i < FRAME - 1) begin
            tick();
            check("gap_cnt_hold", bit_cnt, i + 1);
         end
      end
      check("gap_dout", dout, 8'h4D);
      check("gap_valid", dout_valid, 1);
      tick();
      check("gap_drain", dout_valid, 0);
      dout_ready = 1'b0;
      send_frame(ep(8'hA5), 1'b0);
      check("bp_first", dout, 8'hA5);
      check("bp_first_valid", dout_valid, 1);
      check("bp_first_ovf", overflow, 0);
      send_frame(ep(8'h3C), 1'b0);
      check("bp_hold", dout, 8'hA5);
      check("bp_hold_valid", dout_valid, 1);
      check("bp_ovf", overflow, 1);
      dout_ready = 1'b1;
      tick();
      check("bp_xfer_valid", dout_valid, 0);
      dout_ready = 1'b0;
      tick();
      check("bp_dropped_absent", dout_valid, 0);
      check("bp_dout_kept", dout, 8'hA5);
      check("bp_ovf_sticky", overflow, 1);
      for (int i = 0; i < 5; i++)
         send_bit(1'b1);
      check("clr_pre_cnt", bit_cnt, 5);
      sin = 1'b1;
      sin_valid = 1'b1;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      sin_valid = 1'b0;
      check("clr_cnt", bit_cnt, 0);
      check("clr_ovf", overflow, 0);
      send_frame(ep(8'h11), 1'b0);
      check("sim_hold", dout, 8'h11);
      check("sim_hold_valid", dout_valid, 1);
      send_frame(ep(8'h22), 1'b1);
      check("sim_dout", dout, 8'h22);
      check("sim_valid", dout_valid, 1);
      check("sim_ovf", overflow, 0);
      send_frame(ep(8'h81), 1'b1);
      check("b2b_first", dout, 8'h81);
      send_frame(ep(8'h7E), 1'b1);
      check("b2b_second", dout, 8'h7E);
      check("b2b_valid", dout_valid, 1);
      tick();
      check("b2b_drain", dout_valid, 0);
      dout_ready = 1'b0;
      send_frame(ep(8'h5A), 1'b0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_buf_valid", dout_valid, 1);
      check("clr_buf_dout", dout, 8'h5A);
      dout_ready = 1'b1;
      tick();
      check("clr_buf_drain", dout_valid, 0);
`ifdef SIPO_PARITY_EN
      send_frame({1'b1, 8'h07}, 1'b1);
      check("par_ok_dout", dout, 8'h07);
      check("par_ok", parity_err, 0);
      tick();
      send_frame({1'b0, 8'h07}, 1'b0);
      check("par_bad_dout", dout, 8'h07);
      check("par_bad", parity_err, 1);
      send_frame({1'b1, 8'h07}, 1'b0);
      check("par_drop_keep", parity_err, 1);
      check("par_drop_ovf", overflow, 1);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
